adc_axis_packer: RTL and testbench

- Generalised ADC-to-AXI-Stream packer. Takes NUM_CH parallel ADC samples per valid strobe and sign- or zero-extends each one into a LANE_WIDTH lane.
- Delays data and valid together through a DELAY-stage pipeline, then buffers the beats in a first-word-fall-through (FWFT) FIFO.
- Drives an AXI-Stream master with real tready backpressure, frame-based tlast, and sticky overflow reporting.
- Sits between the ADC capture interface and the wavelet/DMA stream path.

---
 rtl/adc_axis_packer.sv | 108 ++++++++++
 tb/tb_adc_axis_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_axis_packer.sv
// ADC-to-AXI-Stream packer: extends each channel sample into a lane, delays data and
// valid in lockstep, and buffers beats in a FWFT FIFO with framing and sticky overflow.
module adc_axis_packer #(
    parameter int ADC_WIDTH  = 14,
    parameter int LANE_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int DELAY      = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 256,
    parameter int SIGN_EXT   = 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_CH*ADC_WIDTH-1:0]       adc_data_in,
    input  logic                              adc_data_valid,
    output logic [NUM_CH*LANE_WIDTH-1:0]      M_AXIS_OUT_tdata,
    output logic                              M_AXIS_OUT_tvalid,
    input  logic                              M_AXIS_OUT_tready,
    output logic                              M_AXIS_OUT_tlast,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow,
    input  logic                              overflow_clr
);
    localparam int DW = NUM_CH * LANE_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(FRAME_LEN - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [DW-1:0] fmt_data;
    logic          pipe_valid [DELAY+1];
    logic [DW-1:0] pipe_data  [DELAY+1];
    logic [DW-1:0] mem        [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] beat_cnt;
    logic          rd_en;
    logic          wr_req;
    logic          wr_en;

    // Bits above the sample copy its MSB (sign) or stay zero; equal widths pass through.
    always_comb begin
        fmt_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < LANE_WIDTH; b++) begin
                if (b < ADC_WIDTH)
                    fmt_data[c*LANE_WIDTH + b] = adc_data_in[c*ADC_WIDTH + b];
                else if (SIGN_EXT != 0)
                    fmt_data[c*LANE_WIDTH + b] = adc_data_in[c*ADC_WIDTH + ADC_WIDTH - 1];
            end
        end
    end

    // Stage 0 is the format register; stages 1..DELAY are the extra delay.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i <= DELAY; i++) pipe_valid[i] <= 1'b0;
        end else begin
            pipe_valid[0] <= adc_data_valid;
            for (int i = 1; i <= DELAY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= fmt_data;
        for (int i = 1; i <= DELAY; i++) pipe_data[i] <= pipe_data[i-1];
    end

    assign rd_en  = M_AXIS_OUT_tvalid && M_AXIS_OUT_tready;
    assign wr_req = pipe_valid[DELAY];
    // A full FIFO still accepts a write when a beat leaves at the same edge.
    assign wr_en  = wr_req && ((fifo_level != FULL_LEVEL) || rd_en);

    assign M_AXIS_OUT_tvalid = (fifo_level != '0);
    assign M_AXIS_OUT_tdata  = M_AXIS_OUT_tvalid ? mem[rd_ptr] : '0;
    assign M_AXIS_OUT_tlast  = M_AXIS_OUT_tvalid && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pipe_data[DELAY];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            beat_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // A drop at the same edge as a clear leaves the flag set.
            if (wr_req && !wr_en)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_axis_packer.sv
// Bench for adc_axis_packer: sign- and zero-extending instances driven in parallel and
// compared each cycle against a reference queue of accepted samples.
module tb_adc_axis_packer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [27:0] adc_data_in = '0;
    logic        adc_data_valid = 1'b0;
    logic        tready = 1'b0;
    logic        overflow_clr = 1'b0;

    logic [31:0] tdata, z_tdata;
    logic        tvalid, z_tvalid, tlast, z_tlast;
    logic [3:0]  level, z_level;
    logic        ovf, z_ovf;

    always #5 clk = ~clk;

    adc_axis_packer #(.ADC_WIDTH(14), .LANE_WIDTH(16), .NUM_CH(2), .DELAY(3),
                      .FIFO_DEPTH(8), .FRAME_LEN(4), .SIGN_EXT(1)) dut (
        .clk(clk), .resetn(resetn), .adc_data_in(adc_data_in), .adc_data_valid(adc_data_valid),
        .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid), .M_AXIS_OUT_tready(tready),
        .M_AXIS_OUT_tlast(tlast), .fifo_level(level), .overflow(ovf), .overflow_clr(overflow_clr)
    );

    adc_axis_packer #(.ADC_WIDTH(14), .LANE_WIDTH(16), .NUM_CH(2), .DELAY(3),
                      .FIFO_DEPTH(8), .FRAME_LEN(4), .SIGN_EXT(0)) dut_zx (
        .clk(clk), .resetn(resetn), .adc_data_in(adc_data_in), .adc_data_valid(adc_data_valid),
        .M_AXIS_OUT_tdata(z_tdata), .M_AXIS_OUT_tvalid(z_tvalid), .M_AXIS_OUT_tready(tready),
        .M_AXIS_OUT_tlast(z_tlast), .fifo_level(z_level), .overflow(z_ovf), .overflow_clr(overflow_clr)
    );

    // Reference state: raw samples accepted into the FIFO, in-flight pipeline, frame count.
    logic [27:0] exp_q[$];
    logic [27:0] pd[4];
    bit          pv[4];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          xfer_pending = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_drop = 0;
    int          n_tlast = 0;

    function automatic logic [31:0] pack_s(input logic [27:0] r);
        return {{2{r[27]}}, r[27:14], {2{r[13]}}, r[13:0]};
    endfunction

    function automatic logic [31:0] pack_z(input logic [27:0] r);
        return {2'b00, r[27:14], 2'b00, r[13:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the reference by the edge just taken, using the inputs that edge sampled.
    task automatic model_update();
        bit rd, wr_req, space;
        if (!resetn) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            rd     = xfer_pending;
            wr_req = pv[3];
            space  = (exp_q.size() < 8) || rd;
            if (rd) begin
                void'(exp_q.pop_front());
                m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
            end
            if (wr_req && space) exp_q.push_back(pd[3]);
            if (wr_req && !space) begin
                m_ovf = 1'b1;
                n_drop++;
            end else if (overflow_clr) begin
                m_ovf = 1'b0;
            end
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = adc_data_valid;
            pd[0] = adc_data_in;
        end
    endtask

    task automatic check_outputs();
        bit          ev;
        logic [27:0] head;
        ev   = (exp_q.size() != 0);
        head = ev ? exp_q[0] : 28'h0;
        check("tvalid", tvalid, ev);
        check("tdata", tdata, ev ? pack_s(head) : 32'h0);
        check("tlast", tlast, ev && (m_cnt == 3));
        check("level", level, exp_q.size());
        check("overflow", ovf, m_ovf);
        check("zx_tvalid", z_tvalid, ev);
        check("zx_tdata", z_tdata, ev ? pack_z(head) : 32'h0);
        check("zx_tlast", z_tlast, ev && (m_cnt == 3));
        check("zx_level", z_level, exp_q.size());
        check("zx_overflow", z_ovf, m_ovf);
    endtask

    task automatic step(input bit v, input logic [27:0] d, input bit rdy,
                        input bit clr = 1'b0, input bit rstn = 1'b1);
        @(negedge clk);
        model_update();
        check_outputs();
        adc_data_valid = v;
        adc_data_in    = d;
        tready         = rdy;
        overflow_clr   = clr;
        resetn         = rstn;
        xfer_pending   = rstn && rdy && (exp_q.size() != 0);
    endtask

    task automatic do_reset();
        step(1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 28'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state.
        do_reset();
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_level", level, 4'd0);
        check("rst_overflow", ovf, 1'b0);

        // Single beat: latency and extension.
        step(1'b1, {14'h1FFF, 14'h2001}, 1'b1);
        repeat (4) step(1'b0, 28'h0, 1'b1);
        check("lat_tvalid_low", tvalid, 1'b0);
        step(1'b0, 28'h0, 1'b1);
        check("lat_tvalid_high", tvalid, 1'b1);
        check("sign_tdata", tdata, 32'h1FFF_E001);
        check("zero_tdata", z_tdata, 32'h1FFF_2001);
        step(1'b0, 28'h0, 1'b1);
        check("one_beat_only", tvalid, 1'b0);

        // Backpressure: ten samples into an eight-deep FIFO.
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, {14'(i + 100), 14'(i)}, 1'b0);
        repeat (3) step(1'b0, 28'h0, 1'b0);
        check("bp_level_full", level, 4'd8);
        check("bp_no_ovf_yet", ovf, 1'b0);
        step(1'b0, 28'h0, 1'b0);
        check("bp_ovf_9th", ovf, 1'b1);
        step(1'b0, 28'h0, 1'b0);
        check("bp_stall_head", tdata, pack_s({14'd101, 14'd1}));
        repeat (10) step(1'b0, 28'h0, 1'b1);
        check("bp_drained", level, 4'd0);

        // Full FIFO with simultaneous read, then clear coincident with a drop.
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, 28'($urandom()), (i >= 12));
        check("full_rw_level", level, 4'd8);
        check("full_rw_no_ovf", ovf, 1'b0);
        repeat (3) step(1'b1, 28'($urandom()), 1'b0);
        step(1'b1, 28'($urandom()), 1'b0, 1'b1);
        step(1'b1, 28'($urandom()), 1'b0);
        check("clr_vs_set", ovf, 1'b1);
        repeat (6) step(1'b0, 28'h0, 1'b0);
        step(1'b0, 28'h0, 1'b0, 1'b1);
        step(1'b0, 28'h0, 1'b0);
        check("clr_alone", ovf, 1'b0);
        repeat (12) step(1'b0, 28'h0, 1'b1);

        // Framing with mid-frame reset.
        do_reset();
        n_tlast = 0;
        for (int i = 0; i < 13; i++) begin
            step(i < 10, 28'($urandom()), 1'b1);
            if (tvalid && tlast) n_tlast++;
        end
        check("frame_tlast_count", n_tlast, 2);
        step(1'b0, 28'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 28'h0, 1'b1);
        check("midframe_rst_tvalid", tvalid, 1'b0);
        check("midframe_rst_level", level, 4'd0);
        n_tlast = 0;
        for (int i = 0; i < 16; i++) begin
            step(i < 6, 28'($urandom()), 1'b1);
            if (tvalid && tlast) n_tlast++;
        end
        check("restart_tlast_count", n_tlast, 1);

        // Random traffic against the reference.
        do_reset();
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 1) == 1, 28'($urandom()), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0);
        repeat (20) step(1'b0, 28'h0, 1'b1);
        check("random_drained", level, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
